pipe_execute_stage: RTL and testbench

- Parametrised, registered execute stage for the Y86-64 pipeline.
- Computes valE, evaluates the branch/cmov condition against an internal condition-code register, and updates that register.
- Drives the E→M pipeline register with stall/bubble control.
- Sits between the decode-side E register and the memory stage; exports combinational e_* signals to the forwarding/hazard logic.

---
 rtl/pipe_pkg.sv | 61 ++++++
 rtl/pipe_execute_stage_alu_cc_core.sv | 41 ++++
 rtl/pipe_execute_stage.sv | 193 +++++++++++++++++++
 tb/tb_pipe_execute_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the Y86-64 execute stage: status codes, icodes, ALU and
// condition function codes, CC reset value and the multiplier FSM state type.
package pipe_pkg;

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // Default-width register ID "none"; the stage derives its own from RID_W.
  localparam logic [3:0] RNONE = 4'hF;

  // {ZF,SF,OF}
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {MulIdle, MulRun} mul_state_e;

  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = (sf ^ of) | zf;
      C_L:      cond_eval = sf ^ of;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = ~zf;
      C_GE:     cond_eval = ~(sf ^ of);
      C_G:      cond_eval = ~(sf ^ of) & ~zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_execute_stage_alu_cc_core.sv
// Combinational Y86-64 ALU: add/sub/and/xor of aluA and aluB plus ZF/SF/OF.
// Subtract computes b - a.
module alu_cc_core #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_result,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of
);

  logic w_sa, w_sb, w_sr;

  always_comb begin
    case (i_op)
      2'd0:    o_result = i_b + i_a;
      2'd1:    o_result = i_b - i_a;
      2'd2:    o_result = i_b & i_a;
      default: o_result = i_b ^ i_a;
    endcase
  end

  assign w_sa = i_a[W-1];
  assign w_sb = i_b[W-1];
  assign w_sr = o_result[W-1];

  assign o_zf = (o_result == '0);
  assign o_sf = w_sr;

  always_comb begin
    case (i_op)
      2'd0:    o_of = (w_sa == w_sb) && (w_sr != w_sa);
      2'd1:    o_of = (w_sa != w_sb) && (w_sr != w_sb);
      default: o_of = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_execute_stage.sv
// Y86-64 execute stage: valE, branch/cmov condition, CC register and E->M register.
// Define EXEC_MUL_EN to add a two-cycle mulq (OPq ifun 4).
module pipe_execute_stage
  import pipe_pkg::*;
#(
  parameter int unsigned W      = 64,
  parameter int unsigned RID_W  = 4,
  parameter int unsigned STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [W-1:0]      E_valA,
  input  logic [W-1:0]      E_valB,
  input  logic [W-1:0]      E_valC,
  input  logic [RID_W-1:0]  E_dstE,
  input  logic [RID_W-1:0]  E_dstM,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [W-1:0]      e_valE,
  output logic [RID_W-1:0]  e_dstE,
  output logic              e_Cnd,
  output logic              e_busy,
  output logic [2:0]        cc,
  output logic [STAT_W-1:0] M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [W-1:0]      M_valE,
  output logic [W-1:0]      M_valA,
  output logic [RID_W-1:0]  M_dstE,
  output logic [RID_W-1:0]  M_dstM
);

  localparam logic [RID_W-1:0]  W_RNONE = {RID_W{1'b1}};
  localparam logic [STAT_W-1:0] S_BUB   = STAT_W'(STAT_BUB);
  localparam logic [STAT_W-1:0] S_AOK   = STAT_W'(STAT_AOK);
  localparam logic [STAT_W-1:0] S_HLT   = STAT_W'(STAT_HLT);
  localparam logic [STAT_W-1:0] S_ADR   = STAT_W'(STAT_ADR);
  localparam logic [STAT_W-1:0] S_INS   = STAT_W'(STAT_INS);

  logic [W-1:0] w_alu_a, w_alu_b, w_alu_res;
  logic [1:0]   w_alu_op;
  logic         w_alu_zf, w_alu_sf, w_alu_of;
  logic         w_is_opq, w_op_valid, w_bad_op;
  logic         w_zf, w_sf, w_of;
  logic         w_cc_upd, w_busy, w_mul_done;
  logic [W-1:0] w_mul_lo;
  logic         w_mul_of;
  logic [2:0]   r_cc;

  assign w_is_opq = (E_icode == ICODE_OPQ);
`ifdef EXEC_MUL_EN
  assign w_op_valid = (E_ifun <= ALU_MUL);
`else
  assign w_op_valid = (E_ifun <= ALU_XOR);
`endif
  assign w_bad_op = w_is_opq && !w_op_valid;

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (E_icode)
      ICODE_CMOVXX, ICODE_OPQ:                    w_alu_a = E_valA;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:   w_alu_a = E_valC;
      ICODE_CALL, ICODE_PUSHQ:                    w_alu_a = -W'(8);
      ICODE_RET, ICODE_POPQ:                      w_alu_a = W'(8);
      default:                                    w_alu_a = '0;
    endcase
    if (E_icode >= ICODE_RMMOVQ && E_icode <= ICODE_POPQ) w_alu_b = E_valB;
  end

  assign w_alu_op = (w_is_opq && E_ifun <= ALU_XOR) ? E_ifun[1:0] : 2'd0;

  alu_cc_core #(
    .W (W)
  ) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_op     (w_alu_op),
    .o_result (w_alu_res),
    .o_zf     (w_alu_zf),
    .o_sf     (w_alu_sf),
    .o_of     (w_alu_of)
  );

`ifdef EXEC_MUL_EN
  mul_state_e         r_mul_state, w_mul_state_d;
  logic [W-1:0]       r_mul_lo;
  logic               r_mul_of;
  logic [2*W-1:0]     w_prod;
  logic               w_mul_go;

  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign w_prod   = {{W{E_valB[W-1]}}, E_valB} * {{W{E_valA[W-1]}}, E_valA};
  assign w_mul_go = w_is_opq && (E_ifun == ALU_MUL) && (E_stat == S_AOK);

  always_comb begin
    w_mul_state_d = r_mul_state;
    w_busy        = 1'b0;
    case (r_mul_state)
      MulIdle: begin
        if (w_mul_go) begin
          w_busy = 1'b1;
          if (!M_bubble) w_mul_state_d = MulRun;
        end
      end
      MulRun: begin
        if (M_bubble || !M_stall) w_mul_state_d = MulIdle;
      end
      default: w_mul_state_d = MulIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_state <= MulIdle;
      r_mul_lo    <= '0;
      r_mul_of    <= 1'b0;
    end else begin
      r_mul_state <= w_mul_state_d;
      if (r_mul_state == MulIdle && w_mul_go) begin
        r_mul_lo <= w_prod[W-1:0];
        r_mul_of <= (w_prod[2*W-1:W] != {W{w_prod[W-1]}});
      end
    end
  end

  assign w_mul_done = (r_mul_state == MulRun);
  assign w_mul_lo   = r_mul_lo;
  assign w_mul_of   = r_mul_of;
`else
  assign w_busy     = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_lo   = '0;
  assign w_mul_of   = 1'b0;
`endif

  always_comb begin
    e_valE = w_alu_res;
    w_zf   = w_alu_zf;
    w_sf   = w_alu_sf;
    w_of   = w_alu_of;
    if (w_mul_done) begin
      e_valE = w_mul_lo;
      w_zf   = (w_mul_lo == '0);
      w_sf   = w_mul_lo[W-1];
      w_of   = w_mul_of;
    end else if (w_bad_op) begin
      e_valE = '0;
    end
  end

  // Younger instructions must not touch CC once an older one has faulted.
  assign w_cc_upd = w_is_opq && w_op_valid && (E_stat == S_AOK) && !w_busy
                 && !(m_stat == S_ADR || m_stat == S_HLT || m_stat == S_INS)
                 && !(W_stat == S_ADR || W_stat == S_HLT || W_stat == S_INS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cc <= CC_RESET;
    else if (w_cc_upd) r_cc <= {w_zf, w_sf, w_of};
  end

  assign cc     = r_cc;
  assign e_Cnd  = (E_icode == ICODE_CMOVXX || E_icode == ICODE_JXX) ? cond_eval(E_ifun, r_cc)
                                                                    : 1'b0;
  assign e_dstE = (E_icode == ICODE_CMOVXX && !e_Cnd) ? W_RNONE : E_dstE;
  assign e_busy = w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || M_bubble) begin
      M_stat  <= S_BUB;
      M_icode <= ICODE_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= W_RNONE;
      M_dstM  <= W_RNONE;
    end else if (!(M_stall || w_busy)) begin
      M_stat  <= w_bad_op ? S_INS : E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Directed self-checking bench for pipe_execute_stage (default 64-bit configuration).
module tb_pipe_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [3:0]  E_dstE, E_dstM;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd, e_busy;
  logic [2:0]  cc;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  int n_pass  = 0;
  int n_total = 0;

  pipe_execute_stage dut (
    .clk      (clk),
    .rst      (rst),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_valA   (E_valA),
    .E_valB   (E_valB),
    .E_valC   (E_valC),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .M_stall  (M_stall),
    .M_bubble (M_bubble),
    .e_valE   (e_valE),
    .e_dstE   (e_dstE),
    .e_Cnd    (e_Cnd),
    .e_busy   (e_busy),
    .cc       (cc),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                       input logic [3:0] dm);
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = a;
    E_valB  = b;
    E_valC  = c;
    E_dstE  = de;
    E_dstM  = dm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    E_stat = 3'd1; m_stat = 3'd1; W_stat = 3'd1;
    M_stall = 1'b0; M_bubble = 1'b0;
    set_e(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #11;
    check("rst_M_stat", 64'(M_stat), 64'd0);
    check("rst_M_icode", 64'(M_icode), 64'd1);
    check("rst_M_dstE", 64'(M_dstE), 64'hF);
    check("rst_M_valE", M_valE, 64'd0);
    check("rst_cc", 64'(cc), 64'b100);
    check("rst_busy", 64'(e_busy), 64'd0);
    rst = 1'b0;

    // addq 20 + -50
    set_e(4'h6, 4'h0, 64'd20, 64'hFFFF_FFFF_FFFF_FFCE, 64'd0, 4'h2, 4'hF);
    check("add_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFE2);
    check("add_busy", 64'(e_busy), 64'd0);
    tick();
    check("add_cc", 64'(cc), 64'b010);
    check("add_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFE2);
    check("add_M_stat", 64'(M_stat), 64'd1);
    check("add_M_icode", 64'(M_icode), 64'd6);
    check("add_M_dstE", 64'(M_dstE), 64'd2);
    check("add_M_valA", M_valA, 64'd20);

    // subq 50 - (-20)
    set_e(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd50, 64'd0, 4'h2, 4'hF);
    check("sub_e_valE", e_valE, 64'd70);
    tick();
    check("sub_cc", 64'(cc), 64'b000);

    // cmovle after positive result: not taken
    set_e(4'h2, 4'h1, 64'd5, 64'd0, 64'd0, 4'h3, 4'hF);
    check("cmovle_Cnd", 64'(e_Cnd), 64'd0);
    check("cmovle_dstE", 64'(e_dstE), 64'hF);
    check("cmovle_valE", e_valE, 64'd5);
    tick();
    check("cmovle_M_dstE", 64'(M_dstE), 64'hF);
    check("cmovle_M_Cnd", 64'(M_Cnd), 64'd0);

    // signed overflow
    set_e(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF);
    check("ovf_e_valE", e_valE, 64'h8000_0000_0000_0000);
    tick();
    check("ovf_cc", 64'(cc), 64'b011);
    set_e(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jl_Cnd", 64'(e_Cnd), 64'd0);
    set_e(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jle_Cnd", 64'(e_Cnd), 64'd0);
    set_e(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jne_Cnd", 64'(e_Cnd), 64'd1);
    set_e(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("je_Cnd", 64'(e_Cnd), 64'd0);
    set_e(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jg_Cnd", 64'(e_Cnd), 64'd1);
    set_e(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jmp_Cnd", 64'(e_Cnd), 64'd1);
    set_e(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jbad_Cnd", 64'(e_Cnd), 64'd0);
    set_e(4'h2, 4'h5, 64'd9, 64'd0, 64'd0, 4'h5, 4'hF);
    check("cmovge_dstE", 64'(e_dstE), 64'h5);
    set_e(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h4, 4'hF);
    check("irmov_Cnd", 64'(e_Cnd), 64'd0);
    check("irmov_valE", e_valE, 64'h1234);

    // CC gating by later-stage faults
    m_stat = 3'd3;
    set_e(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF);
    check("gate_e_valE", e_valE, 64'd2);
    tick();
    check("gate_m_cc", 64'(cc), 64'b011);
    m_stat = 3'd1;
    W_stat = 3'd4;
    tick();
    check("gate_W_cc", 64'(cc), 64'b011);
    W_stat = 3'd1;
    E_stat = 3'd2;
    tick();
    check("gate_E_cc", 64'(cc), 64'b011);
    E_stat = 3'd1;

    // address arithmetic for non-OPq icodes
    set_e(4'h8, 4'h0, 64'd0, 64'd100, 64'd0, 4'h4, 4'hF);
    check("call_valE", e_valE, 64'd92);
    set_e(4'h9, 4'h0, 64'd0, 64'd100, 64'd0, 4'h4, 4'hF);
    check("ret_valE", e_valE, 64'd108);
    set_e(4'h5, 4'h0, 64'd0, 64'd100, 64'd16, 4'hF, 4'h3);
    check("mrmov_valE", e_valE, 64'd116);
    tick();
    check("mrmov_M_dstM", 64'(M_dstM), 64'd3);

    // and / xor
    set_e(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 4'h1, 4'hF);
    check("and_valE", e_valE, 64'h30);
    tick();
    check("and_cc", 64'(cc), 64'b000);
    set_e(4'h6, 4'h3, 64'h55, 64'h55, 64'd0, 4'h1, 4'hF);
    check("xor_valE", e_valE, 64'd0);
    tick();
    check("xor_cc", 64'(cc), 64'b100);

    // invalid OPq function
    set_e(4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 4'h1, 4'hF);
    check("bad_ifun_valE", e_valE, 64'd0);
    tick();
    check("bad_ifun_M_stat", 64'(M_stat), 64'd4);
    check("bad_ifun_cc", 64'(cc), 64'b100);

    // mulq -6 * 7
    set_e(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFA, 64'd7, 64'd0, 4'h1, 4'hF);
`ifdef EXEC_MUL_EN
    check("mul_busy", 64'(e_busy), 64'd1);
    tick();
    check("mul_hold_M_stat", 64'(M_stat), 64'd4);
    check("mul_busy_drop", 64'(e_busy), 64'd0);
    check("mul_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFD6);
    tick();
    check("mul_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFD6);
    check("mul_cc", 64'(cc), 64'b010);
`else
    check("mul_busy", 64'(e_busy), 64'd0);
    tick();
    check("mul_M_stat", 64'(M_stat), 64'd4);
    check("mul_cc", 64'(cc), 64'b100);
`endif

    // stall then bubble
    set_e(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h6, 4'h7);
    tick();
    check("pre_stall_M_valE", M_valE, 64'd3);
    M_stall = 1'b1;
    set_e(4'h3, 4'h0, 64'd0, 64'd0, 64'd99, 4'h2, 4'hF);
    tick();
    check("stall_M_valE", M_valE, 64'd3);
    check("stall_M_icode", 64'(M_icode), 64'd6);
    check("stall_M_dstE", 64'(M_dstE), 64'd6);
    check("stall_M_dstM", 64'(M_dstM), 64'd7);
    M_bubble = 1'b1;
    tick();
    check("bubble_M_stat", 64'(M_stat), 64'd0);
    check("bubble_M_icode", 64'(M_icode), 64'd1);
    check("bubble_M_dstE", 64'(M_dstE), 64'hF);
    check("bubble_M_valE", M_valE, 64'd0);
    M_stall = 1'b0;
    M_bubble = 1'b0;

    // asynchronous reset between edges
    set_e(4'h6, 4'h0, 64'd20, 64'hFFFF_FFFF_FFFF_FFCE, 64'd0, 4'h2, 4'hF);
    tick();
    check("pre_rst_cc", 64'(cc), 64'b010);
    check("pre_rst_M_stat", 64'(M_stat), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cc", 64'(cc), 64'b100);
    check("async_rst_M_stat", 64'(M_stat), 64'd0);
    check("async_rst_M_valE", M_valE, 64'd0);
    check("async_rst_M_dstE", 64'(M_dstE), 64'hF);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
